// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : keypad_emulator
// Purpose  : Plays back timed 4x4 keypad presses (with optional contact
//            bounce) onto the row lines, in response to the scanned column.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 8,
  parameter int GAP_CYCLES    = 4,
  parameter int BOUNCE_CYCLES = 0,
  parameter int BOUNCE_PERIOD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       done
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_T  = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
  localparam int CW     = $clog2(MAX_T) + 1;

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] LAST_HOLD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LAST_GAP  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] LAST_BNC  = CW'(BOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BOUNCE_IN  = 3'd1,
    S_HOLD       = 3'd2,
    S_BOUNCE_OUT = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    key, key_n;
  logic          key_down, key_down_n;
  logic          done_n;
  logic          bounce_even;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      key      <= '0;
      key_down <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      key      <= key_n;
      key_down <= key_down_n;
      done     <= done_n;
    end
  end

  // key_down is registered from the *next* state/count so the first press
  // level appears in the cycle right after the handshake edge.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + ONE;
    key_n      = key;
    done_n     = 1'b0;
    key_down_n = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (req_valid) begin
          key_n = req_key;
          if (BOUNCE_CYCLES > 0) state_n = S_BOUNCE_IN;
          else                   state_n = S_HOLD;
        end
      end
      S_BOUNCE_IN: begin
        if (cnt == LAST_BNC) begin
          state_n = S_HOLD;
          cnt_n   = '0;
        end
      end
      S_HOLD: begin
        if (cnt == LAST_HOLD) begin
          if (BOUNCE_CYCLES > 0) state_n = S_BOUNCE_OUT;
          else                   state_n = S_GAP;
          cnt_n = '0;
        end
      end
      S_BOUNCE_OUT: begin
        if (cnt == LAST_BNC) begin
          state_n = S_GAP;
          cnt_n   = '0;
        end
      end
      S_GAP: begin
        if (cnt == LAST_GAP) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    bounce_even = ((32'(cnt_n) / 32'(BOUNCE_PERIOD)) % 32'd2) == 32'd0;

    case (state_n)
      S_BOUNCE_IN:  key_down_n = bounce_even;
      S_HOLD:       key_down_n = 1'b1;
      S_BOUNCE_OUT: key_down_n = ~bounce_even;
      default:      key_down_n = 1'b0;
    endcase
  end

  always_comb begin
    row = 4'b0000;
    if (key_down && col[key[3:2]]) row[key[1:0]] = 1'b1;
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

endmodule
`default_nettype wire
